// File: rtl/fetch_pc_dreg.sv
// PC select/predict and F/D pipeline register around the FETCH stage.
// Feeds f_pc to FETCH and captures FETCH outputs into the D register.
module fetch_pc_dreg #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             F_stall,
    input  logic             D_stall,
    input  logic             D_bubble,
    input  logic [3:0]       M_icode,
    input  logic             M_Cnd,
    input  logic [63:0]      M_valA,
    input  logic [3:0]       W_icode,
    input  logic [63:0]      W_valM,
    input  logic [3:0]       f_icode,
    input  logic [3:0]       f_ifun,
    input  logic [3:0]       f_rA,
    input  logic [3:0]       f_rB,
    input  logic [63:0]      f_valC,
    input  logic [63:0]      f_valP,
    input  logic             f_instr_valid,
    input  logic             f_imem_error,
    output logic [63:0]      f_pc,
    output logic [63:0]      F_predPC,
    output logic [2:0]       D_stat,
    output logic [3:0]       D_icode,
    output logic [3:0]       D_ifun,
    output logic [3:0]       D_rA,
    output logic [3:0]       D_rB,
    output logic [63:0]      D_valC,
    output logic [63:0]      D_valP,
    output logic             fetch_halted,
    output logic [CNT_W-1:0] fetch_cnt
);

    localparam logic [3:0] I_HALT = 4'h0;
    localparam logic [3:0] I_NOP  = 4'h1;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;
    localparam logic [3:0] R_NONE = 4'hF;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    logic        mispredict;
    logic        ret_seen;
    logic        correction;
    logic [2:0]  f_stat;
    logic [63:0] pred_next;
    logic        d_load;
    logic        pred_load;

    assign mispredict = (M_icode == I_JXX) && !M_Cnd;
    assign ret_seen   = (W_icode == I_RET);
    assign correction = mispredict || ret_seen;

    always_comb begin
        f_pc = F_predPC;
        if (mispredict)
            f_pc = M_valA;
        else if (ret_seen)
            f_pc = W_valM;
    end

    always_comb begin
        f_stat = S_AOK;
        if (f_imem_error)
            f_stat = S_ADR;
        else if (!f_instr_valid)
            f_stat = S_INS;
        else if (f_icode == I_HALT)
            f_stat = S_HLT;
    end

    assign pred_next = (f_icode == I_JXX || f_icode == I_CALL) ? f_valC : f_valP;

    // A correction restarts fetch on the right path even after a halt.
    assign pred_load = !F_stall && (!fetch_halted || correction);
    assign d_load    = !D_stall && !D_bubble;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            F_predPC <= RESET_PC;
        else if (pred_load)
            F_predPC <= pred_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            D_stat  <= S_AOK;
            D_icode <= I_NOP;
            D_ifun  <= 4'h0;
            D_rA    <= R_NONE;
            D_rB    <= R_NONE;
            D_valC  <= 64'h0;
            D_valP  <= 64'h0;
        end else if (D_stall) begin
            D_stat  <= D_stat;
        end else if (D_bubble) begin
            D_stat  <= S_AOK;
            D_icode <= I_NOP;
            D_ifun  <= 4'h0;
            D_rA    <= R_NONE;
            D_rB    <= R_NONE;
            D_valC  <= 64'h0;
            D_valP  <= 64'h0;
        end else begin
            D_stat  <= f_stat;
            D_icode <= f_imem_error ? I_NOP : f_icode;
            D_ifun  <= f_imem_error ? 4'h0 : f_ifun;
            D_rA    <= f_rA;
            D_rB    <= f_rB;
            D_valC  <= f_valC;
            D_valP  <= f_valP;
        end
    end

    // Clear beats set: a halt captured on a squashed path is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_halted <= 1'b0;
            fetch_cnt    <= '0;
        end else begin
            if (correction)
                fetch_halted <= 1'b0;
            else if (d_load && f_stat != S_AOK)
                fetch_halted <= 1'b1;
            if (d_load)
                fetch_cnt <= fetch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_fetch_pc_dreg.sv
// Scoreboard bench for fetch_pc_dreg: reference model predicts each edge,
// expectations are queued at drive time and popped after the edge.
module tb_fetch_pc_dreg;

    localparam logic [63:0] RPC = 64'h100;
    localparam int          CW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          F_stall, D_stall, D_bubble;
    logic [3:0]    M_icode, W_icode;
    logic          M_Cnd;
    logic [63:0]   M_valA, W_valM;
    logic [3:0]    f_icode, f_ifun, f_rA, f_rB;
    logic [63:0]   f_valC, f_valP;
    logic          f_instr_valid, f_imem_error;
    logic [63:0]   f_pc, F_predPC;
    logic [2:0]    D_stat;
    logic [3:0]    D_icode, D_ifun, D_rA, D_rB;
    logic [63:0]   D_valC, D_valP;
    logic          fetch_halted;
    logic [CW-1:0] fetch_cnt;

    fetch_pc_dreg #(.RESET_PC(RPC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP),
        .f_instr_valid(f_instr_valid), .f_imem_error(f_imem_error),
        .f_pc(f_pc), .F_predPC(F_predPC), .D_stat(D_stat),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .fetch_halted(fetch_halted), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0]   pred;
        logic [2:0]    stat;
        logic [3:0]    icode, ifun, ra, rb;
        logic [63:0]   valc, valp;
        logic          halt;
        logic [CW-1:0] cnt;
    } snap_t;

    snap_t m;
    snap_t sbq[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic snap_t reset_snap();
        snap_t s;
        s.pred  = RPC;
        s.stat  = 3'd1;
        s.icode = 4'h1;
        s.ifun  = 4'h0;
        s.ra    = 4'hF;
        s.rb    = 4'hF;
        s.valc  = '0;
        s.valp  = '0;
        s.halt  = 1'b0;
        s.cnt   = '0;
        return s;
    endfunction

    function automatic logic [63:0] exp_fpc();
        if (M_icode == 4'd7 && M_Cnd == 1'b0) return M_valA;
        if (W_icode == 4'd9) return W_valM;
        return m.pred;
    endfunction

    function automatic snap_t model_next();
        snap_t e;
        logic  fix;
        logic [2:0] st;
        e   = m;
        fix = (M_icode == 4'd7 && !M_Cnd) || (W_icode == 4'd9);
        st  = f_imem_error ? 3'd3 : !f_instr_valid ? 3'd4 :
              (f_icode == 4'd0) ? 3'd2 : 3'd1;
        if (!F_stall && (!m.halt || fix))
            e.pred = (f_icode == 4'd7 || f_icode == 4'd8) ? f_valC : f_valP;
        if (!D_stall && D_bubble) begin
            e = '{pred: e.pred, stat: 3'd1, icode: 4'h1, ifun: 4'h0,
                  ra: 4'hF, rb: 4'hF, valc: 64'h0, valp: 64'h0,
                  halt: m.halt, cnt: m.cnt};
        end else if (!D_stall) begin
            e.stat  = st;
            e.icode = f_imem_error ? 4'h1 : f_icode;
            e.ifun  = f_imem_error ? 4'h0 : f_ifun;
            e.ra    = f_rA;
            e.rb    = f_rB;
            e.valc  = f_valC;
            e.valp  = f_valP;
            e.cnt   = m.cnt + 1'b1;
            if (st != 3'd1) e.halt = 1'b1;
        end
        if (fix) e.halt = 1'b0;
        return e;
    endfunction

    task automatic cmp_all(input string tag, input snap_t e);
        chk({tag, ".predPC"}, F_predPC, e.pred);
        chk({tag, ".stat"}, 64'(D_stat), 64'(e.stat));
        chk({tag, ".icode"}, 64'(D_icode), 64'(e.icode));
        chk({tag, ".ifun"}, 64'(D_ifun), 64'(e.ifun));
        chk({tag, ".rA"}, 64'(D_rA), 64'(e.ra));
        chk({tag, ".rB"}, 64'(D_rB), 64'(e.rb));
        chk({tag, ".valC"}, D_valC, e.valc);
        chk({tag, ".valP"}, D_valP, e.valp);
        chk({tag, ".halted"}, 64'(fetch_halted), 64'(e.halt));
        chk({tag, ".cnt"}, 64'(fetch_cnt), 64'(e.cnt));
    endtask

    // Inputs are already driven at the negedge; check f_pc, then the edge.
    task automatic step(input string tag);
        snap_t e;
        #1;
        chk({tag, ".f_pc"}, f_pc, exp_fpc());
        sbq.push_back(model_next());
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        cmp_all(tag, e);
        m = e;
        @(negedge clk);
    endtask

    task automatic quiet();
        F_stall = 0; D_stall = 0; D_bubble = 0;
        M_icode = 4'd0; M_Cnd = 1'b1; M_valA = '0;
        W_icode = 4'd0; W_valM = '0;
        f_icode = 4'd3; f_ifun = 4'd0; f_rA = 4'd2; f_rB = 4'd5;
        f_valC = 64'h0; f_valP = 64'h0;
        f_instr_valid = 1'b1; f_imem_error = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        m = reset_snap();
        repeat (2) @(negedge clk);
        cmp_all("reset", m);
        rst = 1'b0;

        f_icode = 4'd3; f_valP = 64'd10;
        step("t1_seq");

        f_icode = 4'd7; f_valC = 64'h40; f_valP = 64'h4A;
        step("t2_jpred");

        quiet();
        M_icode = 4'd7; M_Cnd = 1'b0; M_valA = 64'h13; D_bubble = 1'b1;
        step("t2_mispred");

        quiet();
        W_icode = 4'd9; W_valM = 64'h88; f_valP = 64'h90;
        step("t3_ret");
        W_icode = 4'd9; W_valM = 64'h88;
        M_icode = 4'd7; M_Cnd = 1'b0; M_valA = 64'h2C; f_valP = 64'h34;
        step("t3_both");

        quiet();
        f_icode = 4'd6; f_valP = 64'h55;
        step("t4_load");
        D_stall = 1'b1; D_bubble = 1'b1; f_icode = 4'd2; f_valP = 64'h77;
        step("t4_stall_bub");
        quiet();
        F_stall = 1'b1; f_valP = 64'h99;
        step("t4_fstall");

        quiet();
        f_imem_error = 1'b1; f_icode = 4'd6; f_ifun = 4'd3; f_valP = 64'h60;
        step("t5_adr");
        quiet();
        f_valP = 64'hAA;
        step("t5_frozen");
        M_icode = 4'd7; M_Cnd = 1'b0; M_valA = 64'h200; f_valP = 64'h20A;
        step("t5_squash");

        quiet();
        f_instr_valid = 1'b0; f_valP = 64'h300;
        step("t5_ins");
        quiet();
        W_icode = 4'd9; W_valM = 64'h400; f_icode = 4'd0; f_valP = 64'h401;
        step("t5_halt_vs_ret");

        quiet();
        for (int i = 0; i < 80; i++) begin
            F_stall  = ($urandom % 8) == 0;
            D_stall  = ($urandom % 8) == 0;
            D_bubble = ($urandom % 6) == 0;
            M_icode  = ($urandom % 5 == 0) ? 4'd7 : 4'(($urandom % 6));
            M_Cnd    = 1'($urandom);
            M_valA   = {$urandom, $urandom};
            W_icode  = ($urandom % 6 == 0) ? 4'd9 : 4'd5;
            W_valM   = {$urandom, $urandom};
            f_icode  = 4'($urandom_range(0, 11));
            f_ifun   = 4'($urandom);
            f_rA     = 4'($urandom);
            f_rB     = 4'($urandom);
            f_valC   = {$urandom, $urandom};
            f_valP   = {$urandom, $urandom};
            f_instr_valid = ($urandom % 10) != 0;
            f_imem_error  = ($urandom % 12) == 0;
            step("rand");
        end

        quiet();
        f_icode = 4'd0; f_valP = 64'h500;
        step("t6_hlt");
        D_stall = 1'b1; F_stall = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        m = reset_snap();
        cmp_all("t6_async_rst", m);
        @(negedge clk);
        rst = 1'b0;
        quiet();
        f_icode = 4'd3; f_valP = 64'h10;
        step("t6_after_rst");

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
